// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t        : FSM state encoding (idle / shifting / result-valid)
//   DEFAULT_WIDTH  : default operand width
//   cnt_width()    : width of the bit counter for a given operand width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // One extra bit so the counter can represent WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder.
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  always_comb begin
    p    = a ^ b;
    sum  = p ^ cin;
    cout = (a & b) | (cin & p);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are loaded in parallel, added one bit pair per clock
// (LSB first) through a single full-adder cell, and the parallel result is
// presented with a one-cycle done pulse.
//
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the
// operation into a - b (two's complement; cout=1 means no borrow).
//
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   sub      : (SERIAL_ADDER_SUB_EN only) subtract request, captured on accept
//   start    : add request, honoured only in idle or done
//   a_in     : operand A, captured on the accepting edge
//   b_in     : operand B, captured on the accepting edge
//   cin      : carry-in, captured on the accepting edge
//   busy     : high while shifting
//   done     : one-cycle pulse, sum_out/cout freshly valid
//   sum_out  : result register, held until the next result
//   cout     : final carry-out, held with sum_out
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_sum;
  logic             fa_cout;

  // Values loaded on the accepting edge.
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  always_comb begin
    b_load = b_in;
    c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
    // a - b = a + ~b + 1
    if (sub) begin
      b_load = ~b_in;
      c_load = 1'b1;
    end
`endif
  end

  fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      s_sr    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            s_sr  <= '0;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          s_sr  <= {fa_sum, s_sr[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum_out <= {fa_sum, s_sr[WIDTH-1:1]};
            cout    <= fa_cout;
            state   <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);

endmodule
